// File: rtl/mux_rr_reg.sv
// Registered N:1 mux with fixed-select or round-robin grant; one cycle of latency, one word per cycle under full throughput.
// Backpressure: no input is accepted while a held word is stalled. Optional packet lock: define MUX_LOCK_EN.
module mux_rr_reg #(
  parameter  int WIDTH  = 16,
  parameter  int NUM_CH = 4,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
`ifdef MUX_LOCK_EN
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_last,
`endif
  input  logic                    mode,
  input  logic [CW-1:0]           sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [CW-1:0]           out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [CW-1:0]       out_ch_q, out_ch_d;
  logic                out_valid_q, out_valid_d;
  logic [CW-1:0]       ptr_q, ptr_d;

  logic                load;
  logic                xfer;
  logic                gnt_vld;
  logic [CW-1:0]       gnt_idx;
  logic [WIDTH-1:0]    gnt_data;
  logic                gnt_last;
  logic [2*NUM_CH-1:0] vld_dbl;
  logic [NUM_CH-1:0]   vld_rot;
  logic [CW:0]         rr_sum;

`ifdef MUX_LOCK_EN
  logic                lock_q, lock_d;
  logic [CW-1:0]       lock_ch_q, lock_ch_d;
  logic                out_last_q, out_last_d;
`endif

  assign load = !out_valid_q || out_ready;

  // Rotate valids so bit k corresponds to channel (ptr + k) mod NUM_CH.
  assign vld_dbl = {in_valid, in_valid} >> ptr_q;
  assign vld_rot = vld_dbl[NUM_CH-1:0];

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    if (mode) begin
      // Downward scan so the smallest offset from ptr wins.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (vld_rot[k]) begin
          rr_sum = {1'b0, ptr_q} + (CW+1)'(k);
          if (rr_sum >= (CW+1)'(NUM_CH)) begin
            rr_sum = rr_sum - (CW+1)'(NUM_CH);
          end
          gnt_vld = 1'b1;
          gnt_idx = rr_sum[CW-1:0];
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == CW'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = CW'(i);
        end
      end
    end
`ifdef MUX_LOCK_EN
    if (lock_q) begin
      gnt_vld = 1'b0;
      gnt_idx = lock_ch_q;
      for (int i = 0; i < NUM_CH; i++) begin
        if (lock_ch_q == CW'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
        end
      end
    end
`endif
  end

  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == CW'(i)) begin
        gnt_data = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_LOCK_EN
        gnt_last = in_last[i];
`endif
      end
    end
  end

  assign xfer = load && gnt_vld;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = rst_n && xfer && (gnt_idx == CW'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = gnt_vld;
    end
    if (xfer) begin
      out_data_d = gnt_data;
      out_ch_d   = gnt_idx;
      // ptr only moves past a channel once its packet is complete.
      if (mode && gnt_last) begin
        ptr_d = (gnt_idx == CW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

`ifdef MUX_LOCK_EN
  always_comb begin
    lock_d     = lock_q;
    lock_ch_d  = lock_ch_q;
    out_last_d = out_last_q;
    if (xfer) begin
      lock_d     = !gnt_last;
      lock_ch_d  = gnt_idx;
      out_last_d = gnt_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_ch_q  <= lock_ch_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_last = out_last_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed table-driven bench for mux_rr_reg (WIDTH=16, NUM_CH=4).
module tb_mux_rr_reg;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
`ifdef MUX_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;

  mux_rr_reg #(.WIDTH(16), .NUM_CH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef MUX_LOCK_EN
    .in_last  (in_last),
    .out_last (out_last),
`endif
    .mode     (mode),
    .sel      (sel),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [15:0] exp_data;
    logic [1:0]  exp_ch;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a negedge; drives inputs, checks in_ready, then checks registered outputs after the edge.
  task automatic step(input string tag, input vec_t v);
    mode      = v.mode;
    sel       = v.sel;
    in_valid  = v.iv;
    out_ready = v.ordy;
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v.exp_ov));
    chk({tag, ".out_data"}, 64'(out_data), 64'(v.exp_data));
    chk({tag, ".out_ch"}, 64'(out_ch), 64'(v.exp_ch));
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    // ch3..ch0
    in_data   = {16'hA333, 16'hBEEF, 16'hA111, 16'hA000};
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
`ifdef MUX_LOCK_EN
    in_last   = 4'b1111;
`endif

    //             mode  sel   iv       ordy  rdy      ov    data      ch
    tbl[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
    tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'hA000, 2'd0};
    tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'hA111, 2'd1};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 16'hA333, 2'd3};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 16'hA000, 2'd0};
    tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'hA000, 2'd0};
    tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'hA000, 2'd0};
    tbl[8]  = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 16'hA000, 2'd0};
    tbl[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 16'hA111, 2'd1};
    tbl[10] = '{1'b0, 2'd3, 4'b0001, 1'b1, 4'b0000, 1'b0, 16'hA111, 2'd1};
    tbl[11] = '{1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 16'hA000, 2'd0};
    tbl[12] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b1, 16'hA000, 2'd0};
    tbl[13] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 16'hA333, 2'd3};
    tbl[14] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 16'hA000, 2'd0};
    tbl[15] = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 16'hA000, 2'd0};
    tbl[16] = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 16'hA333, 2'd3};
    tbl[17] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 16'hA333, 2'd3};
    tbl[18] = '{1'b1, 2'd0, 4'b0101, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
    tbl[19] = '{1'b1, 2'd0, 4'b0101, 1'b1, 4'b0001, 1'b1, 16'hA000, 2'd0};

    #3;
    chk("reset.in_ready", 64'(in_ready), 64'h0);
    chk("reset.out_valid", 64'(out_valid), 64'h0);
    chk("reset.out_data", 64'(out_data), 64'h0);
    chk("reset.out_ch", 64'(out_ch), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Mid-stream asynchronous reset with ptr parked at 3.
    v = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
    step("pre_rst", v);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst.out_valid", 64'(out_valid), 64'h0);
    chk("async_rst.out_data", 64'(out_data), 64'h0);
    chk("async_rst.out_ch", 64'(out_ch), 64'h0);
    chk("async_rst.in_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 16'hA111, 2'd1};
    step("post_rst", v);

`ifdef MUX_LOCK_EN
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    in_last = 4'b0000;
    v = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0010, 1'b1, 16'hA111, 2'd1};
    step("lock_w1", v);
    chk("lock_w1.out_last", 64'(out_last), 64'h0);
    step("lock_w2", v);
    in_last = 4'b0010;
    step("lock_w3", v);
    chk("lock_w3.out_last", 64'(out_last), 64'h1);
    in_last = 4'b0000;
    v = '{1'b1, 2'd0, 4'b0110, 1'b1, 4'b0100, 1'b1, 16'hBEEF, 2'd2};
    step("lock_next", v);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mux_rr_reg.md
MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the data width per channel in bits (legal range 1..64).
REQ-002 The block SHALL have parameter NUM_CH, default 4, meaning the number of input channels (legal range 2..16).
REQ-003 The block SHALL have a port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have a port rst_n, input, width 1: asynchronous active-low reset.
REQ-005 The block SHALL have a port in_data, input, width NUM_CH*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have a port in_valid, input, width NUM_CH: per-channel valid.
REQ-007 The block SHALL have a port in_ready, output, width NUM_CH: per-channel ready, one-hot or zero.
REQ-008 The block SHALL have a port mode, input, width 1: 0 = fixed select, 1 = round-robin.
REQ-009 The block SHALL have a port sel, input, width CW = $clog2(NUM_CH): channel index used in fixed mode.
REQ-010 The block SHALL have a port out_data, output, width WIDTH: registered selected data.
REQ-011 The block SHALL have a port out_ch, output, width CW: index of the channel that sourced out_data.
REQ-012 The block SHALL have a port out_valid, output, width 1: out_data/out_ch hold a word.
REQ-013 The block SHALL have a port out_ready, input, width 1: downstream accepts the word.

Function
REQ-014 A transfer on channel i SHALL occur in a cycle where in_valid[i] && in_ready[i]; an output transfer occurs where out_valid && out_ready.
REQ-015 The block SHALL define load = !out_valid || out_ready; in_ready SHALL be zero whenever load is 0.
REQ-016 In fixed mode, the block SHALL set in_ready[sel] = load && in_valid[sel]; a sel value >= NUM_CH SHALL grant nothing.
REQ-017 In round-robin mode, the block SHALL grant the first valid channel searching upward from ptr, modulo NUM_CH.
REQ-018 ptr SHALL update to (granted index + 1) mod NUM_CH on every input transfer in round-robin mode, and SHALL stay unchanged in fixed mode.
REQ-019 On an input transfer, out_data and out_ch SHALL load the granted word and index, and out_valid SHALL be 1 on the next cycle (latency 1).
REQ-020 If load is 1 and no grant is made, out_valid SHALL clear to 0 and out_data/out_ch SHALL hold their values.
REQ-021 While out_valid && !out_ready, out_data and out_ch SHALL be stable; no input SHALL be accepted.
REQ-022 When an output transfer and a new input transfer happen in the same cycle, the block SHALL sustain one word per cycle with no bubble.
REQ-023 A change of mode or sel SHALL affect only the next grant and SHALL NOT alter a word already held.
REQ-024 Grant logic SHALL be combinational from in_valid, mode, sel, ptr and load, with no in_ready dependence on in_data.

Reset
REQ-025 Asserting rst_n low SHALL immediately clear out_valid to 0, out_data to 0, out_ch to 0 and ptr to 0; in_ready SHALL read 0 during reset.
REQ-026 A reset asserted mid-stream SHALL discard the held word; the first grant after release SHALL start from channel 0.

Configuration
REQ-027 The macro MUX_LOCK_EN, when defined, SHALL add input in_last (NUM_CH) and output out_last (1, registered with out_data).
REQ-028 With MUX_LOCK_EN defined, after a transfer with in_last[i]=0 the grant SHALL stay locked to channel i (ignoring mode/sel/ptr) until a transfer with in_last[i]=1; ptr SHALL advance only on that final transfer.
REQ-029 Without MUX_LOCK_EN, neither port SHALL exist and every transfer SHALL be independently arbitrated; reset SHALL clear the lock state and out_last.

Verification (WIDTH=16, NUM_CH=4)
REQ-030 Scenario: reset, mode=0, sel=2, in_valid=4'b0100, ch2=16'hBEEF, out_ready=1 -> one cycle later out_valid=1, out_data=BEEF, out_ch=2.
REQ-031 Scenario: mode=1, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
REQ-032 Scenario: word A held, out_ready=0 for 3 cycles with new inputs valid -> in_ready=0, out_data=A stable; out_ready=1 -> A accepted and next word loads on the same edge.
REQ-033 Scenario: mode=0, sel=3 (valid), in_valid=4'b0001 -> no grant, out_valid=0; then set sel=0 -> ch0 granted next cycle.
REQ-034 Scenario: rst_n pulsed low mid-stream, asynchronously to clk -> out_valid=0 at once; after release, mode=1, in_valid=4'b1010 -> first out_ch=1.
REQ-035 Scenario (MUX_LOCK_EN): mode=1, ch1 sends 3 words with in_last on the 3rd while ch2 is valid -> out_ch=1,1,1 then 2.
